reg_scoreboard: RTL and testbench
=================================

Name: reg_scoreboard

Overview:
- Tracks destination registers of in-flight instructions between ID issue and WB retire. The hazard detector consumes `rs1_busy`, `rs2_busy` and `stall` instead of comparing raw pipeline `rd` fields.
- It is the writer side of the pending-register interface. It records every `rd` an instruction will write and clears it when that write retires or the instruction is squashed.
- It sits in the ID stage alongside the hazard unit and is updated from WB and from the branch-flush path.

Parameters:
- NREGS, 32, number of architectural registers; x0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; at most 2^CNT_W-1 outstanding writes per register.
- INFL_W, 4, width of the total in-flight counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  instruction leaving ID this cycle.
- issue_we  in  1  the issuing instruction writes `rd`.
- issue_rd  in  5  destination register of the issuing instruction.
- rs1  in  5  source register 1 of the instruction in ID.
- rs2  in  5  source register 2 of the instruction in ID.
- rs1_used  in  1  `rs1` is read, per opcode class: R/I-load/S/SB.
- rs2_used  in  1  `rs2` is read, per opcode class: R/S/SB.
- retire_valid  in  1  WB writes the register file this cycle.
- retire_rd  in  5  WB destination register.
- kill_valid  in  1  branch flush squashes an issued instruction that writes `rd`.
- kill_rd  in  5  `rd` of the squashed instruction.
- rs1_busy  out  1  `rs1` has a pending write.
- rs2_busy  out  1  `rs2` has a pending write.
- stall  out  1  ID must hold (drives `pc_load`/`if_id_load` low and selects the bubble).
- pending  out  NREGS  bit i set when counter i is nonzero.
- inflight  out  INFL_W  total outstanding tracked writes.
- err_underflow  out  1  sticky flag: a retire or kill arrived for a register with a zero count.

Behaviour:
- **State.**
  - `cnt[i]` is CNT_W bits for i = 1..NREGS-1; `cnt[0]` is constant 0.
  - `inflight` is INFL_W bits; `err_underflow` is 1 bit.
- **Reset.** Reset low forces, asynchronously: all `cnt` = 0, `inflight` = 0, `err_underflow` = 0.
  - Consequently `pending` = 0, and `rs1_busy`, `rs2_busy` and `stall` read 0 while reset is low.
  - Reset mid-operation discards all pending state. The pipeline is flushed by the same reset.
- **Effective events per cycle** (combinational):
  - `inc` = `issue_valid` & `issue_we` & (`issue_rd` != 0) & ~`stall`. An issue during stall is ignored.
  - `dec_r` = `retire_valid` & (`retire_rd` != 0).
  - `dec_k` = `kill_valid` & (`kill_rd` != 0).
- **Counter update per register r** (next edge): `cnt[r]` += `inc`(r) − `dec_r`(r) − `dec_k`(r).
  - Net delta ranges over −2..+1; all combinations in one cycle are legal.
  - Issue and retire to the same `r` in one cycle leaves `cnt` unchanged.
- **Underflow.** If a decrement would take `cnt[r]` below 0, clamp to 0 and set `err_underflow`. The flag stays set until reset.
- **`inflight` update.** `inflight` += `inc` − `dec_r` − `dec_k`, excluding any decrement that underflowed.
- **Busy outputs** (combinational, same cycle, write-before-read register file):
  - `rs1_busy` = `rs1_used` & (`rs1` != 0) & (`cnt[rs1]` != 0).
  - The busy term is suppressed when `cnt[rs1]` == 1 and the same register is being decremented this cycle: `dec_r` or `dec_k` with `retire_rd` or `kill_rd` == `rs1`.
  - `rs2_busy` is identical with `rs2`/`rs2_used`.
- **Stall.** `stall` = `rs1_busy` | `rs2_busy` | `sat`, where `sat` = `issue_we` & (`cnt[issue_rd]` == 2^CNT_W−1).
  - Saturation stalls issue rather than wrapping.
- **Latency.** An issue affects busy from the next cycle. A retire clears busy in the same cycle.
- **No internal FSM** beyond the counters. The counters form a per-register up/down state machine: 0 → 1..MAX → 0.

Decomposition:
- Shared package `riscv_pkg`:
  - opcode constants RTYPE, ITYPE, STYPE, SBTYPE;
  - REG_ADDR_W = 5;
  - NREGS;
  - a typedef for the register index.
- The `rs1_used`/`rs2_used` decode stays in the hazard unit.
- One natural sub-module: `sb_entry`.
  - Contains one CNT_W up/down counter with clamp and underflow flag.
  - Instantiated NREGS−1 times by generate.
- The top level does the decode, the `inflight` counter and the busy/stall muxing.

Test Plan:
- **Reset and idle.** Reset low, then high, with no events → `pending` = 0, `inflight` = 0, `stall` = 0 for rs1 = 5, rs2 = 6 with both used.
- **Issue then dependent read.**
  - Issue `rd` = 5 at cycle 0.
  - Cycle 1, `rs1` = 5 used → `rs1_busy` = 1, `stall` = 1, `pending[5]` = 1, `inflight` = 1.
  - Retire `rd` = 5 at cycle 3 → `rs1_busy` = 0 in cycle 3; `inflight` = 0 at cycle 4.
- **x0 and unused sources.**
  - Issue `rd` = 0 → no counter change.
  - `rs2` = 7 pending with `rs2_used` = 0 (I-type) → `rs2_busy` = 0.
- **Simultaneous issue and retire on `rd` = 9 with `cnt[9]` = 1** → `cnt[9]` stays 1, `inflight` unchanged, busy held.
- **Saturation.**
  - Three issues to `rd` = 3 → `cnt[3]` = 3.
  - A fourth issue to `rd` = 3 → `stall` = 1, issue ignored, `cnt[3]` remains 3.
- **Kill and underflow.**
  - Issue `rd` = 4, then `kill_rd` = 4 → `cnt[4]` = 0, `err_underflow` = 0.
  - A further retire of `rd` = 4 → `cnt[4]` stays 0, `err_underflow` = 1 until reset.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions used by the ID-stage hazard logic.
//   REG_ADDR_W : width of an architectural register index
//   NREGS      : number of architectural registers (x0 included)
//   RTYPE/ITYPE/STYPE/SBTYPE : major opcodes used by the source-use decode
//   reg_idx_t  : register index type
package riscv_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  localparam logic [6:0] RTYPE  = 7'b0110011;
  localparam logic [6:0] ITYPE  = 7'b0010011;
  localparam logic [6:0] STYPE  = 7'b0100011;
  localparam logic [6:0] SBTYPE = 7'b1100011;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  function automatic logic is_x0(input reg_idx_t r);
    return (r == '0);
  endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: pending-write counter for a single register.
//   clock, reset : rising-edge clock, async active-low reset
//   inc          : a new write to this register was issued
//   dec_r, dec_k : a write retired / a write was squashed
//   cnt          : current outstanding-write count
//   uf_amt       : number of decrements this cycle that found nothing to remove
module sb_entry #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec_r,
  input  logic             dec_k,
  output logic [CNT_W-1:0] cnt,
  output logic [1:0]       uf_amt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   up_sum;
  logic [CNT_W:0]   net_sum;
  logic [1:0]       dn_sum;

  always_comb begin
    up_sum  = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};
    dn_sum  = {1'b0, dec_r} + {1'b0, dec_k};
    net_sum = up_sum - {{(CNT_W-1){1'b0}}, dn_sum};
    uf_amt  = '0;
    cnt_d   = cnt_q;
    if (up_sum < {{(CNT_W-1){1'b0}}, dn_sum}) begin
      // Clamp at zero and report how many decrements had nothing to remove.
      uf_amt = dn_sum - up_sum[1:0];
      cnt_d  = '0;
    end else if (net_sum[CNT_W]) begin
      // Saturate; the stall path keeps this unreachable in normal use.
      cnt_d = '1;
    end else begin
      cnt_d = net_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/reg_scoreboard.sv
// Register scoreboard for the ID stage. Counts outstanding writes per
// destination register between issue and WB retire / branch-flush kill,
// and tells the hazard unit whether the current sources are still pending.
//   clock, reset            : rising-edge clock, async active-low reset
//   issue_valid/we/rd       : instruction leaving ID and its destination
//   rs1, rs2, rs1_used/used : sources of the instruction in ID
//   retire_valid/rd         : WB register-file write
//   kill_valid/rd           : squashed instruction's destination
//   rs1_busy, rs2_busy      : source has a pending write
//   stall                   : ID must hold
//   pending                 : per-register nonzero-count map
//   inflight                : total outstanding tracked writes
//   err_underflow           : sticky, a decrement found a zero count
module reg_scoreboard
  import riscv_pkg::*;
#(
  parameter int NREGS  = riscv_pkg::NREGS,
  parameter int CNT_W  = 2,
  parameter int INFL_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic                  retire_valid,
  input  logic [REG_ADDR_W-1:0] retire_rd,
  input  logic                  kill_valid,
  input  logic [REG_ADDR_W-1:0] kill_rd,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  stall,
  output logic [NREGS-1:0]      pending,
  output logic [INFL_W-1:0]     inflight,
  output logic                  err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  cnt_w [NREGS];
  logic [1:0]        uf_w  [NREGS];

  logic              inc, dec_r, dec_k, sat;
  logic [CNT_W-1:0]  cnt_rs1, cnt_rs2, cnt_ird;
  logic              clr_rs1, clr_rs2;
  logic [INFL_W-1:0] uf_total;
  logic [INFL_W-1:0] inflight_q, inflight_d;
  logic              err_q, err_d;

  assign inc   = issue_valid && issue_we && !is_x0(issue_rd) && !stall;
  assign dec_r = retire_valid && !is_x0(retire_rd);
  assign dec_k = kill_valid && !is_x0(kill_rd);

  // x0 is never tracked.
  assign cnt_w[0] = '0;
  assign uf_w[0]  = '0;

  for (genvar g = 1; g < NREGS; g++) begin : g_entry
    sb_entry #(.CNT_W(CNT_W)) u_entry (
      .clock  (clock),
      .reset  (reset),
      .inc    (inc   && (issue_rd  == REG_ADDR_W'(g))),
      .dec_r  (dec_r && (retire_rd == REG_ADDR_W'(g))),
      .dec_k  (dec_k && (kill_rd   == REG_ADDR_W'(g))),
      .cnt    (cnt_w[g]),
      .uf_amt (uf_w[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      pending[i] = (cnt_w[i] != '0);
    end
  end

  // Write-before-read register file: a last pending write retiring (or being
  // killed) this cycle no longer blocks the reader.
  always_comb begin
    cnt_rs1  = cnt_w[rs1];
    cnt_rs2  = cnt_w[rs2];
    cnt_ird  = cnt_w[issue_rd];
    clr_rs1  = (dec_r && (retire_rd == rs1)) || (dec_k && (kill_rd == rs1));
    clr_rs2  = (dec_r && (retire_rd == rs2)) || (dec_k && (kill_rd == rs2));
    rs1_busy = rs1_used && !is_x0(rs1) && (cnt_rs1 != '0)
               && !((cnt_rs1 == CNT_ONE) && clr_rs1);
    rs2_busy = rs2_used && !is_x0(rs2) && (cnt_rs2 != '0)
               && !((cnt_rs2 == CNT_ONE) && clr_rs2);
    sat      = issue_we && (cnt_ird == CNT_MAX);
    stall    = rs1_busy || rs2_busy || sat;
  end

  // Decrements that underflowed were never counted, so add them back.
  always_comb begin
    uf_total = '0;
    for (int i = 1; i < NREGS; i++) begin
      uf_total = uf_total + INFL_W'(uf_w[i]);
    end
    inflight_d = inflight_q + INFL_W'(inc) - INFL_W'(dec_r) - INFL_W'(dec_k)
                 + uf_total;
    err_d      = err_q || (uf_total != '0);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign inflight      = inflight_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clock;
  logic        reset;
  logic        issue_valid, issue_we;
  logic [4:0]  issue_rd, rs1, rs2, retire_rd, kill_rd;
  logic        rs1_used, rs2_used, retire_valid, kill_valid;
  logic        rs1_busy, rs2_busy, stall, err_underflow;
  logic [31:0] pending;
  logic [3:0]  inflight;

  reg_scoreboard dut (
    .clock         (clock),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_we      (issue_we),
    .issue_rd      (issue_rd),
    .rs1           (rs1),
    .rs2           (rs2),
    .rs1_used      (rs1_used),
    .rs2_used      (rs2_used),
    .retire_valid  (retire_valid),
    .retire_rd     (retire_rd),
    .kill_valid    (kill_valid),
    .kill_rd       (kill_rd),
    .rs1_busy      (rs1_busy),
    .rs2_busy      (rs2_busy),
    .stall         (stall),
    .pending       (pending),
    .inflight      (inflight),
    .err_underflow (err_underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        b1;
    logic        b2;
    logic        st;
    logic [31:0] pend;
    logic [3:0]  infl;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s.%s actual=%h required=%h", name, field, act, want);
    end
  endtask

  // Monitor: one expectation per cycle, compared mid-cycle on the falling edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.name, "rs1_busy", 32'(rs1_busy),      32'(e.b1));
      chk(e.name, "rs2_busy", 32'(rs2_busy),      32'(e.b2));
      chk(e.name, "stall",    32'(stall),         32'(e.st));
      chk(e.name, "pending",  pending,            e.pend);
      chk(e.name, "inflight", 32'(inflight),      32'(e.infl));
      chk(e.name, "err_uf",   32'(err_underflow), 32'(e.err));
    end
  end

  task automatic drv(input logic iv, input logic we, input logic [4:0] ird,
                     input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2,
                     input logic rv, input logic [4:0] rrd,
                     input logic kv, input logic [4:0] krd);
    issue_valid  = iv;  issue_we  = we;  issue_rd  = ird;
    rs1          = r1;  rs1_used  = u1;
    rs2          = r2;  rs2_used  = u2;
    retire_valid = rv;  retire_rd = rrd;
    kill_valid   = kv;  kill_rd   = krd;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic iss(input logic [4:0] rd);
    drv(1, 1, rd, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic ret(input logic [4:0] rd);
    drv(0, 0, 0, 0, 0, 0, 0, 1, rd, 0, 0);
  endtask

  task automatic ex(input string name, input logic b1, input logic b2,
                    input logic st, input logic [31:0] pend,
                    input logic [3:0] infl, input logic err);
    exp_t e;
    e.name = name; e.b1 = b1; e.b2 = b2; e.st = st;
    e.pend = pend; e.infl = infl; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    tick();

    drv(0, 0, 0, 5, 1, 6, 1, 0, 0, 0, 0);
    ex("rst_low", 0, 0, 0, 0, 0, 0);                            tick();
    reset = 1'b1;
    ex("rst_idle", 0, 0, 0, 0, 0, 0);                           tick();

    iss(5);                      ex("iss5", 0, 0, 0, 0, 0, 0);  tick();
    drv(0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    ex("dep5", 1, 0, 1, 32'h20, 1, 0);                          tick();
    ex("dep5_hold", 1, 0, 1, 32'h20, 1, 0);                     tick();
    drv(0, 0, 0, 5, 1, 0, 0, 1, 5, 0, 0);
    ex("ret5_bypass", 0, 0, 0, 32'h20, 1, 0);                   tick();
    drv(0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0);
    ex("ret5_done", 0, 0, 0, 0, 0, 0);                          tick();

    iss(0);                      ex("iss_x0", 0, 0, 0, 0, 0, 0); tick();
    idle();                      ex("x0_none", 0, 0, 0, 0, 0, 0); tick();

    iss(7);                      ex("iss7", 0, 0, 0, 0, 0, 0);  tick();
    drv(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 0);
    ex("rs2_unused", 0, 0, 0, 32'h80, 1, 0);                    tick();
    drv(0, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    ex("rs2_used", 0, 1, 1, 32'h80, 1, 0);                      tick();
    ret(7);                      ex("ret7", 0, 0, 0, 32'h80, 1, 0); tick();
    idle();                      ex("ret7_done", 0, 0, 0, 0, 0, 0); tick();

    iss(9);                      ex("iss9", 0, 0, 0, 0, 0, 0);  tick();
    drv(1, 1, 9, 0, 0, 0, 0, 1, 9, 0, 0);
    ex("iss_ret9", 0, 0, 0, 32'h200, 1, 0);                     tick();
    drv(0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0);
    ex("busy9_held", 1, 0, 1, 32'h200, 1, 0);                   tick();
    ret(9);                      ex("ret9", 0, 0, 0, 32'h200, 1, 0); tick();
    idle();                      ex("ret9_done", 0, 0, 0, 0, 0, 0); tick();

    iss(3);                      ex("iss3_a", 0, 0, 0, 0, 0, 0);   tick();
    iss(3);                      ex("iss3_b", 0, 0, 0, 32'h8, 1, 0); tick();
    iss(3);                      ex("iss3_c", 0, 0, 0, 32'h8, 2, 0); tick();
    iss(3);                      ex("iss3_sat", 0, 0, 1, 32'h8, 3, 0); tick();
    idle();                      ex("sat_ignored", 0, 0, 0, 32'h8, 3, 0); tick();
    ret(3);                      ex("ret3_a", 0, 0, 0, 32'h8, 3, 0); tick();
    ret(3);                      ex("ret3_b", 0, 0, 0, 32'h8, 2, 0); tick();
    ret(3);                      ex("ret3_c", 0, 0, 0, 32'h8, 1, 0); tick();
    idle();                      ex("ret3_done", 0, 0, 0, 0, 0, 0);  tick();

    iss(4);                      ex("iss4", 0, 0, 0, 0, 0, 0);      tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4);
    ex("kill4", 0, 0, 0, 32'h10, 1, 0);                         tick();
    idle();                      ex("kill4_done", 0, 0, 0, 0, 0, 0); tick();
    ret(4);                      ex("ret4_uf", 0, 0, 0, 0, 0, 0);    tick();
    idle();                      ex("uf_flag", 0, 0, 0, 0, 0, 1);    tick();
    idle();                      ex("uf_sticky", 0, 0, 0, 0, 0, 1);  tick();

    iss(10);                     ex("iss10", 0, 0, 0, 0, 0, 1);      tick();
    iss(11);                     ex("iss11", 0, 0, 0, 32'h400, 1, 1); tick();
    drv(0, 0, 0, 0, 0, 0, 0, 1, 10, 1, 11);
    ex("ret_kill_pair", 0, 0, 0, 32'hC00, 2, 1);                tick();
    idle();                      ex("pair_done", 0, 0, 0, 0, 0, 1);  tick();

    iss(2);                      ex("iss2", 0, 0, 0, 0, 0, 1);       tick();
    drv(0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0);
    ex("busy2", 1, 0, 1, 32'h4, 1, 1);                          tick();
    reset = 1'b0;
    ex("rst_mid", 0, 0, 0, 0, 0, 0);                            tick();
    reset = 1'b1;
    ex("after_rst", 0, 0, 0, 0, 0, 0);                          tick();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
